mainfsm_ext: RTL and testbench

//  Main control FSM for the multicycle ARM datapath; successor to the fixed 10-state main FSM.

---
 rtl/mainfsm_ext.sv | 230 +++++++++++++++++++++++
 tb/tb_mainfsm_ext.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mainfsm_ext.sv
// ----------------------------------------------------------------------------
// mainfsm_ext
// Main control FSM for the multicycle ARM datapath. Decodes Op/Funct into
// the per-state datapath control word, with a memory wait-state handshake
// on fetch/load/store, a multi-cycle multiply state and an
// undefined-instruction trap.
//
// Parameters
//   MUL_LAT    cycles spent in MULEX (>=1)
//   MEM_HSHK   1: honour MemReady, 0: memory always ready
//   TRAP_HALT  1: UNDEF holds until reset, 0: UNDEF lasts one cycle
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-low reset
//   Op, Funct  instruction fields instr[27:26], instr[25:20]
//   IsMul      instruction is MUL/MLA
//   MemReady   memory completes the current access this cycle
//   NextPC .. ALUOp   datapath control word
//   MulEn      multiplier active (every MULEX cycle)
//   MulStart   pulse on the first MULEX cycle
//   Undef      high while in UNDEF
//   State      current state encoding (debug)
// ----------------------------------------------------------------------------
module mainfsm_ext #(
   parameter int MUL_LAT   = 4,
   parameter bit MEM_HSHK  = 1'b1,
   parameter bit TRAP_HALT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       IsMul,
   input  logic       MemReady,
   output logic       NextPC,
   output logic       Branch,
   output logic       MemW,
   output logic       RegW,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ALUOp,
   output logic       MulEn,
   output logic       MulStart,
   output logic       Undef,
   output logic [3:0] State
);

   localparam int CW = $clog2(MUL_LAT + 1);
   localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      MULEX    = 4'd10,
      MULWB    = 4'd11,
      UNDEF    = 4'd12
   } state_t;

   state_t        state_r;
   logic [CW-1:0] mul_cnt_r;
   logic          rdy_s;

   // Raw (ungated) enables; reset masking is applied at the output ports.
   logic          nextpc_s;
   logic          branch_s;
   logic          memw_s;
   logic          regw_s;
   logic          irwrite_s;

   // Only Funct[5] and Funct[0] steer the FSM; the rest belongs to the ALU decoder.
   logic          unused_funct_s;
   assign unused_funct_s = &{1'b0, Funct[4:1]};

   // Without the handshake the memory is treated as always ready.
   assign rdy_s = MEM_HSHK ? MemReady : 1'b1;

   // State register and multiply latency counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= FETCH;
         mul_cnt_r <= {CW{1'b0}};
      end else begin
         case (state_r)
            FETCH: begin
               if (rdy_s) state_r <= DECODE;
               else       state_r <= FETCH;
            end
            DECODE: begin
               case (Op)
                  2'b00: begin
                     // IsMul outranks the immediate bit.
                     if (IsMul) begin
                        state_r   <= MULEX;
                        mul_cnt_r <= MUL_INIT;
                     end else if (Funct[5]) begin
                        state_r <= EXECUTEI;
                     end else begin
                        state_r <= EXECUTER;
                     end
                  end
                  2'b01:   state_r <= MEMADR;
                  2'b10:   state_r <= BRANCH;
                  default: state_r <= UNDEF;
               endcase
            end
            MEMADR: begin
               if (Funct[0]) state_r <= MEMRD;
               else          state_r <= MEMWR;
            end
            MEMRD: begin
               if (rdy_s) state_r <= MEMWB;
               else       state_r <= MEMRD;
            end
            MEMWB:    state_r <= FETCH;
            MEMWR: begin
               if (rdy_s) state_r <= FETCH;
               else       state_r <= MEMWR;
            end
            EXECUTER: state_r <= ALUWB;
            EXECUTEI: state_r <= ALUWB;
            ALUWB:    state_r <= FETCH;
            BRANCH:   state_r <= FETCH;
            MULEX: begin
               // Loaded with MUL_LAT-1, so exit at zero gives exactly MUL_LAT cycles.
               if (mul_cnt_r == {CW{1'b0}}) begin
                  state_r <= MULWB;
               end else begin
                  mul_cnt_r <= mul_cnt_r - CW'(1);
               end
            end
            MULWB:    state_r <= FETCH;
            UNDEF: begin
               if (TRAP_HALT) state_r <= UNDEF;
               else           state_r <= FETCH;
            end
            default:  state_r <= FETCH;
         endcase
      end
   end

   // Moore decode of the control word from the state register.
   always_comb begin
      nextpc_s  = 1'b0;
      branch_s  = 1'b0;
      memw_s    = 1'b0;
      regw_s    = 1'b0;
      irwrite_s = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 1'b0;
      MulEn     = 1'b0;
      MulStart  = 1'b0;
      Undef     = 1'b0;
      case (state_r)
         FETCH: begin
            nextpc_s  = rdy_s;
            irwrite_s = rdy_s;
            ResultSrc = 2'b10;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
         end
         DECODE: begin
            ResultSrc = 2'b10;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
         end
         MEMADR: begin
            ResultSrc = 2'b10;
            ALUSrcB   = 2'b01;
         end
         MEMRD: AdrSrc = 1'b1;
         MEMWB: begin
            regw_s    = 1'b1;
            ResultSrc = 2'b01;
         end
         MEMWR: begin
            memw_s = 1'b1;
            AdrSrc = 1'b1;
         end
         EXECUTER: ALUOp = 1'b1;
         EXECUTEI: begin
            ALUSrcB = 2'b01;
            ALUOp   = 1'b1;
         end
         ALUWB: begin
            regw_s    = 1'b1;
            ResultSrc = 2'b00;
         end
         BRANCH: begin
            branch_s  = 1'b1;
            ResultSrc = 2'b10;
            ALUSrcB   = 2'b01;
         end
         MULEX: begin
            MulEn    = 1'b1;
            // Counter still holds its load value only on the entry cycle.
            MulStart = (mul_cnt_r == MUL_INIT);
         end
         MULWB: begin
            regw_s    = 1'b1;
            ResultSrc = 2'b11;
         end
         UNDEF:   Undef = 1'b1;
         default: Undef = 1'b0;
      endcase
   end

   // Write enables are masked immediately while reset is held low.
   assign NextPC  = nextpc_s  & reset;
   assign Branch  = branch_s  & reset;
   assign MemW    = memw_s    & reset;
   assign RegW    = regw_s    & reset;
   assign IRWrite = irwrite_s & reset;
   assign State   = state_r;

endmodule

// File: tb/tb_mainfsm_ext.sv
// ----------------------------------------------------------------------------
// tb_mainfsm_ext
// Two instances share stimulus: A (MUL_LAT=4, TRAP_HALT=0) and
// B (MUL_LAT=1, TRAP_HALT=1). Each directed cycle pushes the hand-derived
// expected state / MulStart for both instances into a queue; a monitor on
// the falling edge pops each entry and compares the full output set.
// ----------------------------------------------------------------------------
module tb_mainfsm_ext;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       IsMul;
   logic       MemReady;

   logic       a_NextPC, a_Branch, a_MemW, a_RegW, a_IRWrite, a_AdrSrc;
   logic [1:0] a_ResultSrc, a_ALUSrcA, a_ALUSrcB;
   logic       a_ALUOp, a_MulEn, a_MulStart, a_Undef;
   logic [3:0] a_State;
   logic       b_NextPC, b_Branch, b_MemW, b_RegW, b_IRWrite, b_AdrSrc;
   logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB;
   logic       b_ALUOp, b_MulEn, b_MulStart, b_Undef;
   logic [3:0] b_State;

   int checks   = 0;
   int failures = 0;
   int cyc_no   = 0;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic [3:0] sa;
      logic [3:0] sb;
      logic       msa;
      logic       msb;
      logic       chk_cnt;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   mainfsm_ext #(.MUL_LAT(4), .MEM_HSHK(1'b1), .TRAP_HALT(1'b0)) dut_a (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul), .MemReady(MemReady),
      .NextPC(a_NextPC), .Branch(a_Branch), .MemW(a_MemW), .RegW(a_RegW), .IRWrite(a_IRWrite),
      .AdrSrc(a_AdrSrc), .ResultSrc(a_ResultSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
      .ALUOp(a_ALUOp), .MulEn(a_MulEn), .MulStart(a_MulStart), .Undef(a_Undef), .State(a_State)
   );

   mainfsm_ext #(.MUL_LAT(1), .MEM_HSHK(1'b1), .TRAP_HALT(1'b1)) dut_b (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul), .MemReady(MemReady),
      .NextPC(b_NextPC), .Branch(b_Branch), .MemW(b_MemW), .RegW(b_RegW), .IRWrite(b_IRWrite),
      .AdrSrc(b_AdrSrc), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
      .ALUOp(b_ALUOp), .MulEn(b_MulEn), .MulStart(b_MulStart), .Undef(b_Undef), .State(b_State)
   );

   // Reference control word from the state table:
   // {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,MulEn,Undef}
   function automatic logic [14:0] ref_word(input logic [3:0] s, input logic rdy, input logic rst);
      logic [14:0] w;
      case (s)
         4'd0:    w = {rdy, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
         4'd1:    w = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
         4'd2:    w = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
         4'd3:    w = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
         4'd4:    w = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
         4'd5:    w = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
         4'd6:    w = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
         4'd7:    w = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
         4'd8:    w = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
         4'd9:    w = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
         4'd10:   w = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
         4'd11:   w = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
         4'd12:   w = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
         default: w = 15'd0;
      endcase
      if (!rst) w[14:10] = 5'b00000;
      return w;
   endfunction

   // Monitor: every cycle the DUTs present a full output set; compare it against the queued entry.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t        e;
         logic [19:0] act_a, act_b, req_a, req_b;
         e     = exp_q.pop_front();
         act_a = {a_State, a_MulStart, a_NextPC, a_Branch, a_MemW, a_RegW, a_IRWrite, a_AdrSrc,
                  a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_MulEn, a_Undef};
         act_b = {b_State, b_MulStart, b_NextPC, b_Branch, b_MemW, b_RegW, b_IRWrite, b_AdrSrc,
                  b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_MulEn, b_Undef};
         req_a = {e.sa, e.msa, ref_word(e.sa, e.rdy, e.rst)};
         req_b = {e.sb, e.msb, ref_word(e.sb, e.rdy, e.rst)};
         checks++;
         if (act_a !== req_a) begin
            failures++;
            $display("FAIL outputs_A cyc=%0d actual=%h required=%h", cyc_no, act_a, req_a);
         end
         checks++;
         if (act_b !== req_b) begin
            failures++;
            $display("FAIL outputs_B cyc=%0d actual=%h required=%h", cyc_no, act_b, req_b);
         end
         if (e.chk_cnt) begin
            checks++;
            if (dut_a.mul_cnt_r !== 3'd0) begin
               failures++;
               $display("FAIL mul_cnt_reset cyc=%0d actual=%0d required=0", cyc_no, dut_a.mul_cnt_r);
            end
         end
         cyc_no++;
      end
   end

   task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic im);
      Op    = op;
      Funct = fn;
      IsMul = im;
   endtask

   // One clock cycle: drive inputs, queue the expected response, advance past the edge.
   task automatic cyc(input logic r, input logic rdy, input logic [3:0] sa, input logic [3:0] sb,
                      input logic msa, input logic msb, input logic cc);
      exp_t e;
      reset    = r;
      MemReady = rdy;
      e.rst = r; e.rdy = rdy; e.sa = sa; e.sb = sb; e.msa = msa; e.msb = msb; e.chk_cnt = cc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b0;
      MemReady = 1'b1;
      set_instr(2'b00, 6'b000100, 1'b0);
      @(posedge clk);
      #1;
      // Reset held: FETCH, all enables masked
      cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      // ADD register: 0,1,6,8
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0);
      // LDR: FETCH stalls once, MEMRD held 4 cycles, then MEMWB
      set_instr(2'b01, 6'b000001, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
      // STR: MEMWR for 3 cycles (2 wait states)
      set_instr(2'b01, 6'b000000, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
      // MUL: A spends 4 cycles in MULEX, B one; B parks in FETCH with MemReady low
      set_instr(2'b00, 6'b000000, 1'b1);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd10, 4'd10, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 4'd10, 4'd11, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd11, 4'd0, 1'b0, 1'b0, 1'b0);
      // Data-processing immediate: 0,1,7,8
      set_instr(2'b00, 6'b101000, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0);
      // Branch: 0,1,9
      set_instr(2'b10, 6'b000000, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
      // Undefined: A leaves UNDEF after one cycle, B halts there
      set_instr(2'b11, 6'b000000, 1'b0);
      cyc(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd12, 4'd12, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0);
      // A starts a multiply, reset lands mid-MULEX; B released from UNDEF by reset
      set_instr(2'b00, 6'b000000, 1'b1);
      cyc(1'b1, 1'b1, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd1, 4'd12, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd10, 4'd12, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'd10, 4'd12, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
